// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter step sequencer.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DONE = 3'd2,
        CAPTURE   = 3'd3,
        WAIT_RTZ  = 3'd4,
        ERROR     = 3'd5
    } pc_state_t;

    localparam logic [1:0] INC_FETCH = 2'b01;
    localparam logic [1:0] INC_HOLD  = 2'b00;

endpackage

// File: rtl/pc_sync_bit.sv
// Multi-flop synchronizer bringing one asynchronous level into the clk domain.
module pc_sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pc_step_sequencer.sv
// Arbitrates fetch/branch step requests and runs the 4-phase handshake with the
// self-timed PC ring, capturing each new PC value for the clocked core.
module pc_step_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned TIMEOUT_CYC   = 64,
    parameter int unsigned MAX_BR_STREAK = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_fetch_req,
    output logic             o_fetch_gnt,
    input  logic             i_br_req,
    input  logic [1:0]       i_br_step,
    output logic             o_br_gnt,
    output logic [1:0]       o_pc_inc,
    output logic             o_pc_ack,
    input  logic             i_pc_done,
    input  logic [WIDTH-1:0] i_pc_data,
    output logic [WIDTH-1:0] o_pc_value,
    output logic             o_pc_valid,
    output logic             o_busy,
    output logic             o_err,
    input  logic             i_err_clr
);

    localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned STREAK_W = (MAX_BR_STREAK < 1) ? 1 : $clog2(MAX_BR_STREAK + 1);
    localparam int unsigned WARM_W   = $clog2(SYNC_STAGES + 1);

    pc_state_t            r_state;
    logic                 r_fetch_gnt;
    logic                 r_br_gnt;
    logic [1:0]           r_pc_inc;
    logic                 r_pc_ack;
    logic [WIDTH-1:0]     r_pc_value;
    logic                 r_pc_valid;
    logic                 r_busy;
    logic                 r_err;
    logic [TMO_W-1:0]     r_tmo_cnt;
    logic [STREAK_W-1:0]  r_streak;
    logic [WARM_W-1:0]    r_warm_cnt;
    logic [WIDTH-1:0]     r_data_s1;
    logic [WIDTH-1:0]     r_data_s2;

    logic w_done_s;
    logic w_warm_done;
    logic w_arb_open;
    logic w_streak_max;
    logic w_fetch_wins;
    logic w_grant;
    logic w_tmo_hit;
    logic w_data_stable;

    pc_sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_done (
        .clk (clk),
        .rst (rst),
        .i_d (i_pc_done),
        .o_q (w_done_s)
    );

    // The synchronizer output is meaningless until it has been filled after reset;
    // without this a held-high pc_done would look low for SYNC_STAGES cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_warm_cnt <= '0;
        end else if (!w_warm_done) begin
            r_warm_cnt <= r_warm_cnt + WARM_W'(1);
        end
    end

    // Two consecutive samples of the bundled data word; agreement means it has settled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_s1 <= '0;
            r_data_s2 <= '0;
        end else begin
            r_data_s1 <= i_pc_data;
            r_data_s2 <= r_data_s1;
        end
    end

    assign w_warm_done   = (r_warm_cnt == WARM_W'(SYNC_STAGES));
    assign w_arb_open    = (r_state == IDLE) && w_warm_done && !w_done_s;
    assign w_streak_max  = (r_streak == STREAK_W'(MAX_BR_STREAK));
    assign w_fetch_wins  = i_fetch_req && (!i_br_req || w_streak_max);
    assign w_grant       = w_arb_open && (i_fetch_req || i_br_req);
    assign w_tmo_hit     = (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign w_data_stable = (r_data_s1 == r_data_s2);

    // Consecutive branch grants made while a fetch is starved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_streak <= '0;
        end else if (!i_fetch_req) begin
            r_streak <= '0;
        end else if (w_grant) begin
            if (w_fetch_wins) begin
                r_streak <= '0;
            end else if (!w_streak_max) begin
                r_streak <= r_streak + STREAK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_fetch_gnt <= 1'b0;
            r_br_gnt    <= 1'b0;
            r_pc_inc    <= INC_HOLD;
            r_pc_ack    <= 1'b0;
            r_pc_value  <= '0;
            r_pc_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_tmo_cnt   <= '0;
        end else begin
            r_fetch_gnt <= 1'b0;
            r_br_gnt    <= 1'b0;
            r_pc_valid  <= 1'b0;
            r_tmo_cnt   <= r_tmo_cnt + TMO_W'(1);

            case (r_state)
                IDLE: begin
                    r_tmo_cnt <= '0;
                    if (w_grant) begin
                        r_state <= ISSUE;
                        r_busy  <= 1'b1;
                        if (w_fetch_wins) begin
                            r_fetch_gnt <= 1'b1;
                            r_pc_inc    <= INC_FETCH;
                        end else begin
                            r_br_gnt <= 1'b1;
                            r_pc_inc <= i_br_step;
                        end
                    end
                end

                // pc_inc has been stable for this whole cycle before ack rises.
                ISSUE: begin
                    r_tmo_cnt <= '0;
                    r_pc_ack  <= 1'b1;
                    r_state   <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    if (w_done_s) begin
                        r_state   <= CAPTURE;
                        r_tmo_cnt <= '0;
                    end else if (w_tmo_hit) begin
                        r_state   <= ERROR;
                        r_err     <= 1'b1;
                        r_pc_ack  <= 1'b0;
                        r_pc_inc  <= INC_HOLD;
                        r_busy    <= 1'b0;
                        r_tmo_cnt <= '0;
                    end
                end

                CAPTURE: begin
                    if (w_data_stable) begin
                        r_pc_value <= r_data_s2;
                        r_pc_valid <= 1'b1;
                        r_pc_ack   <= 1'b0;
                        r_state    <= WAIT_RTZ;
                        r_tmo_cnt  <= '0;
                    end else if (w_tmo_hit) begin
                        r_state   <= ERROR;
                        r_err     <= 1'b1;
                        r_pc_ack  <= 1'b0;
                        r_pc_inc  <= INC_HOLD;
                        r_busy    <= 1'b0;
                        r_tmo_cnt <= '0;
                    end
                end

                WAIT_RTZ: begin
                    if (!w_done_s) begin
                        r_state   <= IDLE;
                        r_pc_inc  <= INC_HOLD;
                        r_busy    <= 1'b0;
                        r_tmo_cnt <= '0;
                    end else if (w_tmo_hit) begin
                        r_state   <= ERROR;
                        r_err     <= 1'b1;
                        r_pc_ack  <= 1'b0;
                        r_pc_inc  <= INC_HOLD;
                        r_busy    <= 1'b0;
                        r_tmo_cnt <= '0;
                    end
                end

                // Recovery goes through WAIT_RTZ so done is seen low before any new grant.
                ERROR: begin
                    r_tmo_cnt <= '0;
                    if (i_err_clr) begin
                        r_err   <= 1'b0;
                        r_state <= WAIT_RTZ;
                        r_busy  <= 1'b1;
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    r_pc_ack  <= 1'b0;
                    r_pc_inc  <= INC_HOLD;
                    r_busy    <= 1'b0;
                    r_tmo_cnt <= '0;
                end
            endcase
        end
    end

    assign o_fetch_gnt = r_fetch_gnt;
    assign o_br_gnt    = r_br_gnt;
    assign o_pc_inc    = r_pc_inc;
    assign o_pc_ack    = r_pc_ack;
    assign o_pc_value  = r_pc_value;
    assign o_pc_valid  = r_pc_valid;
    assign o_busy      = r_busy;
    assign o_err       = r_err;

endmodule
